// File: rtl/gate_bank_pkg.sv
// Shared types and truth table for the gate-bank self-test.
// expected_y is the golden response the checker compares the bank against.
package gate_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } gb_state_e;

  localparam int GB_NOT_A = 0;
  localparam int GB_NOT_B = 1;
  localparam int GB_NOR   = 2;
  localparam int GB_OR    = 3;
  localparam int GB_AND   = 4;
  localparam int GB_NAND  = 5;
  localparam int GB_XOR   = 6;
  localparam int GB_XNOR  = 7;

  localparam int GB_WIDTH = 8;

  // Vector index is {a,b}.
  function automatic logic [GB_WIDTH-1:0] expected_y(input logic [1:0] v);
    logic a;
    logic b;
    logic [GB_WIDTH-1:0] y;
    a = v[1];
    b = v[0];
    y = '0;
    y[GB_NOT_A] = ~a;
    y[GB_NOT_B] = ~b;
    y[GB_NOR]   = ~(a | b);
    y[GB_OR]    = a | b;
    y[GB_AND]   = a & b;
    y[GB_NAND]  = ~(a & b);
    y[GB_XOR]   = a ^ b;
    y[GB_XNOR]  = ~(a ^ b);
    return y;
  endfunction

endpackage

// File: rtl/gate_bank_checker_if.sv
// Stimulus/response link between the checker (master) and the gate bank (slave).
// Signal names follow the checker's point of view: a_o/b_o out, y_i back in.
interface gate_bank_checker_if;
  logic       a_o;
  logic       b_o;
  logic [7:0] y_i;

  modport master (output a_o, output b_o, input y_i);
  modport slave  (input a_o, input b_o, output y_i);
endinterface

// File: rtl/gate_bank_ref_model.sv
// Behavioural 2-in/8-out gate bank with per-bit fault injection.
// Purely combinational; stuck-at-1 overrides stuck-at-0, both apply after inversion.
module gate_bank_ref_model
  import gate_bank_pkg::*;
(
  gate_bank_checker_if.slave gb,
  input  logic [7:0]         stuck0_i,
  input  logic [7:0]         stuck1_i,
  input  logic [7:0]         flip_i
);

  logic [7:0] ideal;

  always_comb begin
    ideal   = expected_y({gb.a_o, gb.b_o});
    gb.y_i  = ((ideal ^ flip_i) & ~stuck0_i) | stuck1_i;
  end

endmodule

// File: rtl/gate_bank_checker.sv
// Self-test engine: walks {a,b} through 0..3 for LOOPS passes, samples y after SETTLE_CYCLES.
// Run takes 4*LOOPS*(SETTLE_CYCLES+1)+1 cycles from start to done; start is ignored while busy.
module gate_bank_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  gate_bank_checker_if.master gb,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          fail_mask,
  output logic [7:0]          err_count,
  output logic [1:0]          first_fail_vec
);
  import gate_bank_pkg::*;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  gb_state_e  state_q;
  logic [1:0] v_q;
  logic [7:0] loop_q;
  logic [3:0] settle_q;
  logic       a_q, b_q;
  logic       busy_q, done_q, pass_q;
  logic [7:0] fail_mask_q, err_count_q;
  logic [1:0] first_fail_q;

  logic [7:0] diff;
  logic [7:0] fail_mask_d, err_count_d;
  logic [1:0] first_fail_d;
  logic [1:0] v_inc;

  always_comb begin
    diff         = gb.y_i ^ expected_y(v_q);
    fail_mask_d  = fail_mask_q | diff;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    v_inc        = v_q + 2'd1;
    if (diff != 8'h00) begin
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      // An empty mask means no earlier sample of this run mismatched.
      if (fail_mask_q == 8'h00) first_fail_d = v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      v_q          <= 2'd0;
      loop_q       <= 8'd0;
      settle_q     <= 4'd0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 8'h00;
      err_count_q  <= 8'h00;
      first_fail_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            fail_mask_q  <= 8'h00;
            err_count_q  <= 8'h00;
            first_fail_q <= 2'd0;
            pass_q       <= 1'b0;
            v_q          <= 2'd0;
            loop_q       <= 8'd0;
            settle_q     <= 4'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= DRIVE;
          end
        end
        DRIVE: begin
          a_q <= v_q[1];
          b_q <= v_q[0];
          if (settle_q == SETTLE_LAST) begin
            settle_q <= 4'd0;
            state_q  <= SAMPLE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        SAMPLE: begin
          fail_mask_q  <= fail_mask_d;
          err_count_q  <= err_count_d;
          first_fail_q <= first_fail_d;
          if (v_q != 2'd3) begin
            v_q     <= v_inc;
            a_q     <= v_inc[1];
            b_q     <= v_inc[0];
            state_q <= DRIVE;
          end else if (loop_q < LOOP_LAST) begin
            v_q     <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            loop_q  <= loop_q + 8'd1;
            state_q <= DRIVE;
          end else begin
            // Verdict includes whatever the final sample contributes.
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (fail_mask_d == 8'h00);
            state_q <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gb.a_o          = a_q;
  assign gb.b_o          = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_mask       = fail_mask_q;
  assign err_count       = err_count_q;
  assign first_fail_vec  = first_fail_q;

endmodule

// File: tb/tb_gate_bank_checker.sv
// Bench for gate_bank_checker: table of fault scenarios, random faults vs a vector-level model,
// plus hand-written reset-abort, start-while-busy and start-with-reset sequences.
module tb_gate_bank_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v;
  logic [7:0] s0, s1, fl;

  gate_bank_checker_if gb0 ();
  gate_bank_checker_if gb1 ();
  gate_bank_checker_if gb2 ();

  gate_bank_ref_model bank0 (.gb(gb0), .stuck0_i(s0), .stuck1_i(s1), .flip_i(fl));
  gate_bank_ref_model bank1 (.gb(gb1), .stuck0_i(s0), .stuck1_i(s1), .flip_i(fl));
  gate_bank_ref_model bank2 (.gb(gb2), .stuck0_i(s0), .stuck1_i(s1), .flip_i(fl));

  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] fm0, ec0, fm1, ec1, fm2, ec2;
  logic [1:0] ff0, ff1, ff2;

  gate_bank_checker #(.SETTLE_CYCLES(2), .LOOPS(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .gb(gb0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_mask(fm0), .err_count(ec0), .first_fail_vec(ff0));
  gate_bank_checker #(.SETTLE_CYCLES(2), .LOOPS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .gb(gb1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(fm1), .err_count(ec1), .first_fail_vec(ff1));
  gate_bank_checker #(.SETTLE_CYCLES(1), .LOOPS(255)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .gb(gb2), .busy(busy2), .done(done2),
    .pass(pass2), .fail_mask(fm2), .err_count(ec2), .first_fail_vec(ff2));

  int         sel;
  logic       a_m, b_m, busy_m, done_m, pass_m;
  logic [7:0] fm_m, ec_m;
  logic [1:0] ff_m;

  always_comb begin
    case (sel)
      1: begin
        a_m = gb1.a_o; b_m = gb1.b_o; busy_m = busy1; done_m = done1; pass_m = pass1;
        fm_m = fm1; ec_m = ec1; ff_m = ff1;
      end
      2: begin
        a_m = gb2.a_o; b_m = gb2.b_o; busy_m = busy2; done_m = done2; pass_m = pass2;
        fm_m = fm2; ec_m = ec2; ff_m = ff2;
      end
      default: begin
        a_m = gb0.a_o; b_m = gb0.b_o; busy_m = busy0; done_m = done0; pass_m = pass0;
        fm_m = fm0; ec_m = ec0; ff_m = ff0;
      end
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int settle_of(input int s);
    return (s == 2) ? 1 : 2;
  endfunction

  function automatic int loops_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 255);
  endfunction

  // Vector-level reference: what each sample looks like, then tally the run.
  function automatic void model(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] mf,
                                input int loops, output logic [7:0] mask, output logic [7:0] errs,
                                output logic [1:0] ffv, output logic ok);
    logic [7:0] golden [4];
    logic [7:0] y;
    logic [7:0] d;
    int         n;
    golden[0] = 8'hA7; golden[1] = 8'h69; golden[2] = 8'h6A; golden[3] = 8'h98;
    mask = 8'h00; ffv = 2'd0; n = 0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        y = ((golden[v] ^ mf) & ~m0) | m1;
        d = y ^ golden[v];
        if (d != 8'h00) begin
          if (mask == 8'h00) ffv = 2'(v);
          n++;
        end
        mask = mask | d;
      end
    end
    errs = (n > 255) ? 8'd255 : 8'(n);
    ok   = (mask == 8'h00);
  endfunction

  task automatic run_check(input string tag, input int s, input logic [7:0] m0,
                           input logic [7:0] m1, input logic [7:0] mf, input int rk);
    int         st, lp, lat, k, done_k;
    logic [7:0] em, ee;
    logic [1:0] ef;
    logic       ep, ab_ok, busy_ok, quiet_ok;
    logic [1:0] ev;
    sel = s; s0 = m0; s1 = m1; fl = mf;
    st  = settle_of(s);
    lp  = loops_of(s);
    lat = 4 * lp * (st + 1) + 1;
    model(m0, m1, mf, lp, em, ee, ef, ep);
    @(negedge clk); start_v[s] = 1'b1;
    @(posedge clk); #1; start_v[s] = 1'b0;
    k = 1; done_k = 0; ab_ok = 1'b1; busy_ok = 1'b1;
    while (k <= lat + 5 && done_k == 0) begin
      if (done_m === 1'b1) begin
        done_k = k;
      end else begin
        if (k < lat) begin
          ev = 2'(((k - 1) / (st + 1)) % 4);
          if ({a_m, b_m} !== ev) ab_ok = 1'b0;
          if (busy_m !== 1'b1) busy_ok = 1'b0;
        end
        if (k == rk || k == rk + 3) start_v[s] = 1'b1;
        @(posedge clk); #1; start_v[s] = 1'b0;
        k++;
      end
    end
    chk({tag, ".done_cycle"}, done_k, lat);
    chk({tag, ".ab_seq"}, ab_ok, 1);
    chk({tag, ".busy_run"}, busy_ok, 1);
    chk({tag, ".busy_at_done"}, busy_m, 0);
    chk({tag, ".pass"}, pass_m, ep);
    chk({tag, ".fail_mask"}, fm_m, em);
    chk({tag, ".err_count"}, ec_m, ee);
    chk({tag, ".first_fail"}, ff_m, ef);
    quiet_ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_m !== 1'b0 || busy_m !== 1'b0) quiet_ok = 1'b0;
    end
    chk({tag, ".single_done_idle"}, quiet_ok, 1);
    chk({tag, ".results_hold"}, {pass_m, fm_m, ec_m, ff_m}, {ep, em, ee, ef});
  endtask

  typedef struct {
    string      name;
    int         s;
    logic [7:0] m0, m1, mf;
    logic [7:0] emask, eerr;
    logic [1:0] effv;
    logic       epass;
  } vec_t;

  initial begin
    vec_t       tbl [6];
    logic [7:0] mm, me;
    logic [1:0] mf2;
    logic       mp;
    logic       ok;

    tbl[0] = '{"clean",      0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0,   2'b00, 1'b1};
    tbl[1] = '{"y6_sa0",     0, 8'h40, 8'h00, 8'h00, 8'h40, 8'd2,   2'b01, 1'b0};
    tbl[2] = '{"y4_sa1_x3",  1, 8'h00, 8'h10, 8'h00, 8'h10, 8'd9,   2'b00, 1'b0};
    tbl[3] = '{"all_inv",    0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'd4,   2'b00, 1'b0};
    tbl[4] = '{"y0_sa1_x3",  1, 8'h00, 8'h01, 8'h00, 8'h01, 8'd6,   2'b10, 1'b0};
    tbl[5] = '{"inv_sat255", 2, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'd255, 2'b00, 1'b0};

    rst = 1'b1; start_v = 3'b000; s0 = 8'h00; s1 = 8'h00; fl = 8'h00; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", {gb0.a_o, gb0.b_o, busy0, done0, pass0, fm0, ec0, ff0}, 0);
    chk("reset.outputs_d2", {gb2.a_o, gb2.b_o, busy2, done2, pass2, fm2, ec2, ff2}, 0);
    @(negedge clk); rst = 1'b0;

    // The table's expectations are literal values; also cross-check the model against them.
    for (int i = 0; i < 6; i++) begin
      model(tbl[i].m0, tbl[i].m1, tbl[i].mf, loops_of(tbl[i].s), mm, me, mf2, mp);
      chk({tbl[i].name, ".model"}, {mm, me, mf2, mp},
          {tbl[i].emask, tbl[i].eerr, tbl[i].effv, tbl[i].epass});
      run_check(tbl[i].name, tbl[i].s, tbl[i].m0, tbl[i].m1, tbl[i].mf, 0);
    end

    // Reset in the 5th cycle of a run aborts it with no done pulse.
    sel = 0; s0 = 8'h00; s1 = 8'h00; fl = 8'hFF;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort.pre_err", ec_m, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort.state", {a_m, b_m, busy_m, done_m, pass_m, fm_m, ec_m, ff_m}, 0);
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_m !== 1'b0 || busy_m !== 1'b0) ok = 1'b0;
    end
    chk("abort.no_done", ok, 1);
    run_check("after_abort", 0, 8'h00, 8'h00, 8'h00, 0);

    // start pulses while busy must not disturb the run.
    run_check("restart_busy", 0, 8'h40, 8'h00, 8'h00, 4);
    run_check("restart_busy_x3", 1, 8'h00, 8'h08, 8'h00, 10);

    // start coincident with reset: reset wins, block stays idle.
    sel = 0;
    @(negedge clk); rst = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start_v[0] = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      if (busy_m !== 1'b0 || done_m !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("rst_start.idle", ok, 1);
    chk("rst_start.results", {fm_m, ec_m, ff_m, pass_m}, 0);

    // Random fault patterns against the model.
    for (int r = 0; r < 10; r++) begin
      logic [7:0] r0, r1, rf;
      r0 = 8'($urandom & $urandom & $urandom);
      r1 = 8'($urandom & $urandom & $urandom);
      rf = 8'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin r0 = 8'h00; r1 = 8'h00; rf = 8'h00; end
      run_check($sformatf("rand%0d", r), $urandom_range(0, 1), r0, r1, rf, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_bank_checker.md
Name: gate_bank_checker

Overview:
- Self-test engine for the 2-input NOR-built gate bank.
- Drives the bank's a/b inputs through all four input combinations and samples the bank's 8-bit output after a programmable settle time.
- Compares each sample against the expected truth table and reports a per-gate sticky fail mask, a mismatch count and an overall pass flag.
- Sits at the other end of the gate-bank interface from the bank itself: this block produces its stimulus and consumes its response.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- LOOPS, 1, number of full 4-vector passes per run; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a run; ignored unless in IDLE
- a_o  output  1  stimulus bit a to the gate bank
- b_o  output  1  stimulus bit b to the gate bank
- y_i  input  8  gate-bank response; bit map 0 ~a, 1 ~b, 2 nor, 3 or, 4 and, 5 nand, 6 xor, 7 xnor
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at the end of a run
- pass  output  1  valid from done onward: 1 when fail_mask==0
- fail_mask  output  8  sticky; bit i set when y_i[i] mismatched on any vector in this run
- err_count  output  8  number of mismatching samples (vector-level, not bit-level), saturates at 255
- first_fail_vec  output  2  {a,b} of the first mismatching vector; valid when fail_mask!=0

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE;
  - a_o=0, b_o=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, first_fail_vec=0.
  - Reset in the middle of a run aborts the run immediately. No done pulse is produced.
- Vector index v[1:0] = {a,b}, stepping 0,1,2,3. Expected y per vector: 0:0xA7, 1:0x69, 2:0x6A, 3:0x98.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - a_o/b_o hold their last values. Results hold and stay readable.
  - On start=1: clear fail_mask, err_count, first_fail_vec and pass; set v=0, loop=0, settle counter=0, busy=1; go to DRIVE.
- DRIVE:
  - a_o=v[1], b_o=v[0], both registered.
  - The settle counter increments each cycle. After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE (1 cycle):
  - diff = y_i XOR expected(v).
  - fail_mask |= diff.
  - If diff!=0: err_count increments (saturating at 255). If this is the first mismatch of the run, first_fail_vec=v.
  - Then:
    - if v<3: v++, go to DRIVE;
    - else if loop<LOOPS-1: v=0, loop++, go to DRIVE;
    - else go to FINISH.
- FINISH (1 cycle): done=1, busy=0, pass=(fail_mask==0), including any bits set in the final SAMPLE. Next state IDLE.
- Latency: done is high in cycle N+4*LOOPS*(SETTLE_CYCLES+1)+1, where N is the cycle start was sampled.
- start while busy: ignored, with no effect on counters or results.
- start in the same cycle as rst: rst wins.
- y_i is sampled only in SAMPLE. Its value in all other cycles is don't-care.
- The design uses no combinational path from y_i to any output.

Decomposition:
- Package gate_bank_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, FINISH);
  - bit-index constants for the 8 gate outputs (GB_NOT_A..GB_XNOR);
  - function expected_y(input [1:0] v) returning the truth-table byte.
- One natural sub-module: gate_bank_ref_model, a behavioural 2-in/8-out gate bank.
  - It is used by the bench as the DUT stand-in.
  - It can also be instantiated with a fault-injection mask (stuck-at-0/1 per bit).

Test Plan:
1. Fault-free model, SETTLE_CYCLES=2, LOOPS=1, start pulse -> a_o/b_o sequence 00,01,10,11, each held 3 cycles; done 13 cycles after start; pass=1, fail_mask=0x00, err_count=0.
2. y[6] stuck-at-0 -> mismatches on vectors 1 and 2; fail_mask=0x40, err_count=2, first_fail_vec=2'b01, pass=0.
3. y[4] stuck-at-1 with LOOPS=3 -> mismatches on vectors 0,1,2 of each loop; fail_mask=0x10, err_count=9, first_fail_vec=2'b00; done at cycle 37.
4. rst asserted in the 5th cycle of a run -> next cycle busy=0, a_o=b_o=0, all results zero, no done pulse; a fresh start then completes normally.
5. start re-pulsed while busy, and start asserted together with rst -> first run unaffected, with a single done; in the rst case the block stays in IDLE.
6. All 8 outputs inverted (y_i = ~expected) -> fail_mask=0xFF, err_count=4, first_fail_vec=2'b00, pass=0.
